// File: rtl/fop_seq_if.sv
// fop_seq_if: host-side start/stop handshake plus the sequencer's status and
// fop control outputs. The host side uses the master modport and the
// sequencer uses the slave modport.
interface fop_seq_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             fop_reset;
  logic             fop_enable;
  logic [CNT_W-1:0] run_count;

  modport master (
    output start,
    output stop,
    input  busy,
    input  done,
    input  aborted,
    input  fop_reset,
    input  fop_enable,
    input  run_count
  );

  modport slave (
    input  start,
    input  stop,
    output busy,
    output done,
    output aborted,
    output fop_reset,
    output fop_enable,
    output run_count
  );

endinterface

// File: rtl/fop_seq.sv
// fop_seq: control sequencer for the fop core.
// A host start pulse produces a reset pulse of RESET_CYCLES, then an enable
// window of RUN_CYCLES (0 = open-ended until stop), then a one-cycle done
// pulse. A stop during reset or run ends the sequence early with aborted set.
// Optional feature macro: FOP_SEQ_RUNCNT_EN builds the saturating count of
// enabled cycles on run_count; without it run_count is tied to zero.
module fop_seq #(
  parameter int RESET_CYCLES = 1,
  parameter int RUN_CYCLES   = 10,
  parameter int CNT_W        = 16
) (
  input logic      clk,
  input logic      reset_n,
  fop_seq_if.slave bus
);

  // Reload values for the shared down-counter. An open-ended run never uses
  // the counter, so it simply loads zero there.
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   =
    (RUN_CYCLES == 0) ? '0 : CNT_W'(RUN_CYCLES - 1);
  localparam bit               RUN_OPEN   = (RUN_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Reject reset widths that are zero or do not fit in the counter.
  if (RESET_CYCLES < 1 ||
      longint'(RESET_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_reset_cycles
    $error("fop_seq: RESET_CYCLES=%0d outside 1..2^%0d-1", RESET_CYCLES, CNT_W);
  end

  // A negative run length has no meaning.
  if (RUN_CYCLES < 0) begin : g_bad_run_cycles
    $error("fop_seq: RUN_CYCLES=%0d must not be negative", RUN_CYCLES);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             fop_reset_q;
  logic             fop_enable_q;

  // Sequencer FSM; every output is a flop updated together with the state so
  // the fop pins change cleanly on the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      fop_reset_q  <= 1'b0;
      fop_enable_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_RESET;
            cnt         <= RESET_LOAD;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b1;
            fop_reset_q <= 1'b1;
          end
        end

        S_RESET: begin
          if (bus.stop) begin
            state       <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            aborted_q   <= 1'b1;
            fop_reset_q <= 1'b0;
          end else if (cnt == '0) begin
            state        <= S_RUN;
            cnt          <= RUN_LOAD;
            fop_reset_q  <= 1'b0;
            fop_enable_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state        <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            aborted_q    <= 1'b1;
            fop_enable_q <= 1'b0;
          end else if (!RUN_OPEN && cnt == '0) begin
            state        <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            fop_enable_q <= 1'b0;
          end else if (!RUN_OPEN) begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state        <= S_IDLE;
          busy_q       <= 1'b0;
          fop_reset_q  <= 1'b0;
          fop_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.fop_reset  = fop_reset_q;
  assign bus.fop_enable = fop_enable_q;

`ifdef FOP_SEQ_RUNCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] run_cnt_q;

  // Count enabled cycles, clearing on an accepted start and saturating at
  // all-ones; the value holds after done until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_q <= '0;
    end else if (state == S_IDLE && bus.start) begin
      run_cnt_q <= '0;
    end else if (fop_enable_q && run_cnt_q != CNT_MAX) begin
      run_cnt_q <= run_cnt_q + CNT_ONE;
    end
  end

  assign bus.run_count = run_cnt_q;
`else
  assign bus.run_count = '0;
`endif

  // The fop core must never see reset and enable together.
  a_reset_enable_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n) !(fop_reset_q && fop_enable_q)
  );

  // done is a single-cycle pulse.
  a_done_single_cycle : assert property (
    @(posedge clk) disable iff (!reset_n) done_q |=> !done_q
  );

  // busy and done are never high together.
  a_busy_done_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n) !(busy_q && done_q)
  );

endmodule

// File: tb/tb_fop_seq.sv
// tb_fop_seq: self-checking bench for fop_seq. Three instances with different
// reset/run lengths are driven through a vector table, hand-written corner
// sequences and a randomized phase compared with a timeline-based model.
module tb_fop_seq;

`ifdef FOP_SEQ_RUNCNT_EN
  localparam bit RC_ON = 1'b1;
`else
  localparam bit RC_ON = 1'b0;
`endif

  logic tb_clk;
  logic tb_rst_n;
  int   checks;
  int   errors;

  fop_seq_if #(.CNT_W(16)) if_a ();
  fop_seq_if #(.CNT_W(16)) if_b ();
  fop_seq_if #(.CNT_W(16)) if_c ();

  fop_seq dut_a (
    .clk     (tb_clk),
    .reset_n (tb_rst_n),
    .bus     (if_a)
  );

  fop_seq #(.RESET_CYCLES(3), .RUN_CYCLES(0)) dut_b (
    .clk     (tb_clk),
    .reset_n (tb_rst_n),
    .bus     (if_b)
  );

  fop_seq #(.RESET_CYCLES(4), .RUN_CYCLES(10)) dut_c (
    .clk     (tb_clk),
    .reset_n (tb_rst_n),
    .bus     (if_c)
  );

  // Free-running 10-unit clock.
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    bit st;
    bit sp;
    bit busy;
    bit done;
    bit ab;
    bit rst;
    bit en;
    int rc;
  } vec_t;

  // Reference model: time elapsed since the accepted start decides the phase.
  // mode 0 = idle, 1 = sequence in progress, 2 = completion cycle.
  typedef struct {
    int mode;
    int t;
    bit ab;
    int rc;
  } model_t;

  function automatic model_t model_init();
    model_t m;
    m.mode = 0;
    m.t    = 0;
    m.ab   = 1'b0;
    m.rc   = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int r, int n, bit st, bit sp);
    model_t x = m;
    case (m.mode)
      0: if (st) begin
        x.mode = 1;
        x.t    = 0;
        x.ab   = 1'b0;
        x.rc   = 0;
      end
      1: begin
        if (m.t >= r && m.rc < 65535) x.rc = m.rc + 1;
        if (sp) begin
          x.mode = 2;
          x.ab   = 1'b1;
        end else if (n != 0 && m.t + 1 >= r + n) begin
          x.mode = 2;
        end else begin
          x.t = m.t + 1;
        end
      end
      default: x.mode = 0;
    endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic applyStimulus(input int which, input bit st, input bit sp);
    case (which)
      0: begin if_a.start = st; if_a.stop = sp; end
      1: begin if_b.start = st; if_b.stop = sp; end
      default: begin if_c.start = st; if_c.stop = sp; end
    endcase
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 32'(act), 32'(exp));
  endtask

  task automatic checkAll(input string tag, input model_t m, input int r,
                          input logic busy, input logic done, input logic ab,
                          input logic rs, input logic en, input logic [15:0] rc);
    checkBit({tag, ".busy"}, busy, m.mode == 1);
    checkBit({tag, ".done"}, done, m.mode == 2);
    checkBit({tag, ".aborted"}, ab, m.ab);
    checkBit({tag, ".fop_reset"}, rs, m.mode == 1 && m.t < r);
    checkBit({tag, ".fop_enable"}, en, m.mode == 1 && m.t >= r);
    checkOutput({tag, ".run_count"}, 32'(rc), RC_ON ? m.rc : 0);
    checkBit({tag, ".exclusive"}, rs & en, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, ".a_busy"}, if_a.busy, 1'b0);
    checkBit({tag, ".a_done"}, if_a.done, 1'b0);
    checkBit({tag, ".a_aborted"}, if_a.aborted, 1'b0);
    checkBit({tag, ".a_fop_reset"}, if_a.fop_reset, 1'b0);
    checkBit({tag, ".a_fop_enable"}, if_a.fop_enable, 1'b0);
    checkOutput({tag, ".a_run_count"}, 32'(if_a.run_count), 0);
    checkBit({tag, ".b_busy"}, if_b.busy, 1'b0);
    checkBit({tag, ".c_busy"}, if_c.busy, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
    model_t ma;
    model_t mb;
    model_t mc;
    int     en_cycles;
    int     waited;
    bit     got_done;
    bit     st;
    bit     sp;

    checks = 0;
    errors = 0;
    if_a.start = 1'b0; if_a.stop = 1'b0;
    if_b.start = 1'b0; if_b.stop = 1'b0;
    if_c.start = 1'b0; if_c.stop = 1'b0;

    // Scenario 1 on dut_a (reset 1, run 10), then a stop-in-run and a
    // stop-in-reset sequence, with ignored start/stop sprinkled in.
    //              st sp  busy done ab rst en  rc
    tbl.push_back('{1, 0,  1,   0,   0, 1,  0,  0});
    tbl.push_back('{1, 0,  1,   0,   0, 0,  1,  0});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  1});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  2});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  3});
    tbl.push_back('{1, 0,  1,   0,   0, 0,  1,  4});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  5});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  6});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  7});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  8});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  9});
    tbl.push_back('{1, 0,  0,   1,   0, 0,  0, 10});
    tbl.push_back('{1, 1,  0,   0,   0, 0,  0, 10});
    tbl.push_back('{0, 0,  0,   0,   0, 0,  0, 10});
    tbl.push_back('{1, 0,  1,   0,   0, 1,  0,  0});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  0});
    tbl.push_back('{0, 0,  1,   0,   0, 0,  1,  1});
    tbl.push_back('{0, 1,  0,   1,   1, 0,  0,  2});
    tbl.push_back('{0, 1,  0,   0,   1, 0,  0,  2});
    tbl.push_back('{0, 1,  0,   0,   1, 0,  0,  2});
    tbl.push_back('{1, 1,  1,   0,   0, 1,  0,  0});
    tbl.push_back('{0, 1,  0,   1,   1, 0,  0,  0});
    tbl.push_back('{0, 0,  0,   0,   1, 0,  0,  0});

    // Asynchronous reset from a known-high level, checked before any edge.
    tb_rst_n = 1'b1;
    #1 tb_rst_n = 1'b0;
    #2;
    checkAllZero("reset");
    tick();
    tick();
    tb_rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("tbl[%0d]", i);
      applyStimulus(0, tbl[i].st, tbl[i].sp);
      tick();
      checkBit({tag, ".busy"}, if_a.busy, tbl[i].busy);
      checkBit({tag, ".done"}, if_a.done, tbl[i].done);
      checkBit({tag, ".aborted"}, if_a.aborted, tbl[i].ab);
      checkBit({tag, ".fop_reset"}, if_a.fop_reset, tbl[i].rst);
      checkBit({tag, ".fop_enable"}, if_a.fop_enable, tbl[i].en);
      checkOutput({tag, ".run_count"}, 32'(if_a.run_count), RC_ON ? tbl[i].rc : 0);
    end
    applyStimulus(0, 1'b0, 1'b0);

    // Scenario 2 on dut_b: reset 3, open-ended run, stop sampled at edge 8.
    for (int e = 0; e <= 10; e++) begin
      applyStimulus(1, e == 0, e == 8);
      tick();
      checkBit($sformatf("s2.e%0d.fop_reset", e), if_b.fop_reset, e <= 2);
      checkBit($sformatf("s2.e%0d.fop_enable", e), if_b.fop_enable, e >= 3 && e <= 7);
      checkBit($sformatf("s2.e%0d.busy", e), if_b.busy, e <= 7);
      checkBit($sformatf("s2.e%0d.done", e), if_b.done, e == 8);
      checkBit($sformatf("s2.e%0d.aborted", e), if_b.aborted, e >= 8);
    end
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("s2.run_count", 32'(if_b.run_count), RC_ON ? 5 : 0);

    // Scenario 3 on dut_c: stop during a 4-cycle reset pulse.
    for (int e = 0; e <= 4; e++) begin
      applyStimulus(2, e == 0, e == 2);
      tick();
      checkBit($sformatf("s3.e%0d.fop_reset", e), if_c.fop_reset, e < 2);
      checkBit($sformatf("s3.e%0d.fop_enable", e), if_c.fop_enable, 1'b0);
      checkBit($sformatf("s3.e%0d.done", e), if_c.done, e == 2);
      checkBit($sformatf("s3.e%0d.aborted", e), if_c.aborted, e >= 2);
    end
    applyStimulus(2, 1'b0, 1'b0);
    checkOutput("s3.run_count", 32'(if_c.run_count), 0);

    // Scenario 4 on dut_a: start held high gives a 13-cycle repeating pattern.
    applyStimulus(0, 1'b1, 1'b0);
    for (int e = 0; e < 28; e++) begin
      tick();
      checkBit($sformatf("s4.e%0d.fop_reset", e), if_a.fop_reset, (e % 13) == 0);
      checkBit($sformatf("s4.e%0d.fop_enable", e), if_a.fop_enable,
               (e % 13) >= 1 && (e % 13) <= 10);
      checkBit($sformatf("s4.e%0d.done", e), if_a.done, (e % 13) == 11);
      checkBit($sformatf("s4.e%0d.busy", e), if_a.busy, (e % 13) <= 10);
      checkBit($sformatf("s4.e%0d.aborted", e), if_a.aborted, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b0);

    // Scenario 5: dut_a is mid-run; async reset drops everything at once.
    #2 tb_rst_n = 1'b0;
    #1;
    checkAllZero("s5.async");
    tick();
    checkBit("s5.no_done", if_a.done, 1'b0);
    tb_rst_n = 1'b1;
    tick();

    // A fresh start after reset runs a complete, unaborted sequence.
    applyStimulus(0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0);
    checkBit("s5.fresh.fop_reset", if_a.fop_reset, 1'b1);
    en_cycles = 0;
    waited    = 0;
    got_done  = 1'b0;
    while (!got_done && waited < 40) begin
      tick();
      waited++;
      if (if_a.fop_enable) en_cycles++;
      if (if_a.done) got_done = 1'b1;
    end
    checkBit("s5.fresh.done_seen", got_done, 1'b1);
    checkOutput("s5.fresh.enable_cycles", en_cycles, 10);
    checkBit("s5.fresh.aborted", if_a.aborted, 1'b0);
    checkOutput("s5.fresh.run_count", 32'(if_a.run_count), RC_ON ? 10 : 0);

    // Resynchronise all instances with the model, then randomize.
    tb_rst_n = 1'b0;
    #2 tb_rst_n = 1'b1;
    tick();
    ma = model_init();
    mb = model_init();
    mc = model_init();
    for (int cyc = 0; cyc < 600; cyc++) begin
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 11) == 0);
      applyStimulus(0, st, sp);
      ma = model_step(ma, 1, 10, st, sp);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 15) == 0);
      applyStimulus(1, st, sp);
      mb = model_step(mb, 3, 0, st, sp);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 11) == 0);
      applyStimulus(2, st, sp);
      mc = model_step(mc, 4, 10, st, sp);
      tick();
      checkAll($sformatf("rnd%0d.a", cyc), ma, 1, if_a.busy, if_a.done, if_a.aborted,
               if_a.fop_reset, if_a.fop_enable, if_a.run_count);
      checkAll($sformatf("rnd%0d.b", cyc), mb, 3, if_b.busy, if_b.done, if_b.aborted,
               if_b.fop_reset, if_b.fop_enable, if_b.run_count);
      checkAll($sformatf("rnd%0d.c", cyc), mc, 4, if_c.busy, if_c.done, if_c.aborted,
               if_c.fop_reset, if_c.fop_enable, if_c.run_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fop_seq.md
# fop_seq

Control sequencer that drives the `fop` core's `reset`/`enable` pins from a host start/stop handshake. It replaces the hand-timed testbench stimulus with synthesizable logic: reset pulse, then a bounded or open-ended enable window, then a one-cycle completion pulse. It sits between the host/bus control logic and the `fop` instance, sharing its clock.

## Interface
- `RESET_CYCLES`, default 1: width of the `fop_reset` pulse in clock cycles. Legal range is 1 to 2^CNT_W-1.
- `RUN_CYCLES`, default 10: length of the enable window in cycles. 0 means run until `stop`.
- `CNT_W`, default 16: width of the internal counters and of `run_count`.

Ports:
- `clk`, input, 1: single clock, shared with `fop`.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level, sampled each rising edge. Acted on only in IDLE.
- `stop`, input, 1: level, sampled each rising edge. Acted on only in RESET and RUN.
- `busy`, output, 1: high while in RESET or RUN.
- `done`, output, 1: one-cycle pulse when a sequence finishes.
- `aborted`, output, 1: valid with `done`. Set to 1 if the sequence ended by `stop`. Holds its value until the next accepted `start`.
- `fop_reset`, output, 1: active-high, drives `fop.reset`.
- `fop_enable`, output, 1: drives `fop.enable`.
- `run_count`, output, CNT_W: enabled-cycle count. Only meaningful with the macro defined; see Configuration.

## Operation
- States are IDLE, RESET, RUN and DONE. All outputs are registered.
- IDLE: when `start`=1, go to RESET. Load the counter with RESET_CYCLES-1 and clear `aborted`.
- RESET:
  - `fop_reset`=1 and `busy`=1.
  - When the counter reaches 0, go to RUN. Load the counter with RUN_CYCLES-1; the count is unused when RUN_CYCLES=0. Otherwise decrement.
  - `stop`=1 in RESET goes to DONE with `aborted`=1. In that case `fop_enable` never asserts.
- RUN:
  - `fop_enable`=1 and `busy`=1.
  - If RUN_CYCLES≠0 and the counter reaches 0, go to DONE. Otherwise decrement.
  - `stop`=1 goes to DONE with `aborted`=1. `stop` takes priority over the counter expiring on the same edge.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then unconditionally go to IDLE.
- Ignored inputs:
  - `start` in RESET, RUN or DONE is ignored. It is not queued.
  - `stop` in IDLE or DONE is ignored.
  - If `start` and `stop` are both high in IDLE, `start` is accepted and `stop` is ignored for that edge.
- Asynchronous reset, including mid-sequence:
  - State goes to IDLE, and the counters clear.
  - `busy`, `done`, `aborted`, `fop_reset`, `fop_enable` and `run_count` all go to 0 immediately.
  - `fop_enable` drops without a `done` pulse.
- Counter arithmetic is unsigned CNT_W bits, with no wrap in normal use. A RESET_CYCLES value outside the legal range is an elaboration error, raised by an assertion.

## Timing
- Edge k samples `start`=1 in IDLE. From edge k, `fop_reset`=1 and `busy`=1.
- From edge k+RESET_CYCLES: `fop_reset`=0 and `fop_enable`=1 on the same edge. There is no gap cycle.
- From edge k+RESET_CYCLES+RUN_CYCLES, when not stopped: `fop_enable`=0, `busy`=0, `done`=1.
- One edge later: `done`=0, and a new `start` can be sampled.
- Latency from `stop` sampled at edge j to `fop_enable`=0 is edge j, i.e. one register stage. `done`=1 also during the cycle after edge j.
- `fop_reset` and `fop_enable` are never high in the same cycle.

## Configuration
- Macro: `FOP_SEQ_RUNCNT_EN`.
- Defined:
  - `run_count` clears on an accepted `start`.
  - It increments on every cycle with `fop_enable`=1 and saturates at 2^CNT_W-1.
  - It holds after DONE until the next `start`.
- Undefined: `run_count` is tied to 0 and the counter logic is not built. The port remains present, so the instance is the same in both builds.

## Test plan
- Default params, `start` pulsed at edge 2 → `fop_reset` high for 1 cycle from edge 2; `fop_enable` high for 10 cycles from edge 3; `done`=1 from edge 13, `aborted`=0, `run_count`=10.
- RESET_CYCLES=3, RUN_CYCLES=0, `start` at edge 0, `stop` at edge 8 → `fop_reset` high for edges 0–2; `fop_enable` high for edges 3–7; `done` and `aborted`=1 from edge 8; `run_count`=5.
- `stop` asserted during RESET (RESET_CYCLES=4, `stop` at edge 2) → `fop_reset` drops at edge 2; `fop_enable` never asserts; `done`=1, `aborted`=1, `run_count`=0.
- `start` held high continuously → back-to-back sequences, each separated by exactly one DONE cycle and one IDLE cycle; no `start` is queued while `busy`.
- `reset_n` asserted mid-RUN → all outputs go to 0 asynchronously with no `done` pulse; after release, a fresh `start` runs a full, normal sequence.
- With the macro undefined, repeat scenario 1 → identical control waveforms; `run_count` stays 0.
